// File: rtl/sort_arbiter.sv
// rtl/sort_arbiter.sv - round-robin arbiter sharing one sorter between M requesters
// Latches the winner's operands, sequences sorter start/done and returns the result over valid/ready.
module sort_arbiter #(
  parameter int M       = 3,
  parameter int N       = 6,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32,
  localparam int OW     = (M > 1) ? $clog2(M) : 1,
  localparam int VW     = N * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M-1:0]      req,
  input  logic [M*VW-1:0]   req_data,
  output logic [M-1:0]      ack,
  output logic [M-1:0]      rsp_valid,
  input  logic [M-1:0]      rsp_ready,
  output logic [VW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [OW-1:0]     owner,
  output logic              sort_start,
  output logic [VW-1:0]     sort_data,
  input  logic              sort_done,
  input  logic [VW-1:0]     sort_result,
  output logic [15:0]       job_count,
  output logic              timeout_flag
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [OW:0]   M_C      = (OW + 1)'(M);
  localparam logic [OW-1:0] LAST_IDX = OW'(M - 1);

  logic [1:0]    state;
  logic [OW-1:0] ptr;
  logic [TW-1:0] timer;

  logic [VW-1:0] slices [M];
  logic          grant_found;
  logic [OW-1:0] grant_idx;
  logic [OW:0]   cand;

  genvar g;
  generate
    for (g = 0; g < M; g++) begin : g_slice
      assign slices[g] = req_data[g*VW +: VW];
    end
  endgenerate

  // Search starts at ptr and wraps; ptr < M so one subtraction brings the candidate back in range.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < M; i++) begin
      cand = {1'b0, ptr} + (OW + 1)'(i);
      if (cand >= M_C) cand = cand - M_C;
      if (!grant_found && req[cand[OW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[OW-1:0];
      end
    end
  end

  always_comb begin
    ack       = '0;
    rsp_valid = '0;
    if (state == LAUNCH) ack[owner] = 1'b1;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign sort_start = (state == LAUNCH);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      timer        <= '0;
      sort_data    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      job_count    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            owner     <= grant_idx;
            sort_data <= slices[grant_idx];
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A done arriving on the final timer cycle still counts as a good result.
          if (sort_done) begin
            rsp_data <= sort_result;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (timer == T_LAST) begin
            rsp_data     <= '0;
            rsp_err      <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
            if (job_count != 16'hFFFF) job_count <= job_count + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sort_arbiter.md
Name: sort_arbiter

Overview:
- Shares one fsm_sort instance (N elements, WIDTH bits, rising-edge start, one-cycle done pulse) between M requesters.
- Round-robin arbitration, latches the winner's operand vector, and sequences the sorter's start/done.
- Returns the sorted vector to the owner over a valid/ready handshake, with a watchdog on sorter completion.
- Sits between the requester fabric and the sorter; the sorter's own reset is driven elsewhere.

Parameters:
- M, 3, number of requesters (2..8).
- N, 6, elements per job; must match the sorter.
- WIDTH, 8, bits per element; must match the sorter.
- TIMEOUT, 32, max cycles in WAIT before the job is aborted (≥16).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  M  level request per requester; held until ack.
- req_data  in  M*N*WIDTH  operand vectors; slice k = bits [(k+1)*N*WIDTH-1 : k*N*WIDTH]; element e of a slice at bits [e*WIDTH +: WIDTH].
- ack  out  M  one-cycle pulse: request k accepted and operands latched.
- rsp_valid  out  M  result valid for owner (one-hot or zero).
- rsp_ready  in  M  per-requester result acceptance.
- rsp_data  out  N*WIDTH  sorted vector (shared bus).
- rsp_err  out  1  qualifies rsp_valid: job timed out, rsp_data is all zeros.
- busy  out  1  high whenever state != IDLE.
- owner  out  $clog2(M) (min 1)  index of current/last granted requester.
- sort_start  out  1  to sorter start.
- sort_data  out  N*WIDTH  to sorter data_in; registered operand latch.
- sort_done  in  1  from sorter done.
- sort_result  in  N*WIDTH  from sorter data_sorted.
- job_count  out  16  completed jobs (including timeouts); saturates at 0xFFFF.
- timeout_flag  out  1  sticky; set on any timeout; cleared only by reset.

Behaviour:
- Reset (rst=0 at clk edge):
  - State = IDLE; rr pointer = 0; owner = 0; timer = 0.
  - All outputs 0: ack, rsp_valid, rsp_err, rsp_data, sort_start, sort_data, job_count, timeout_flag; busy = 0.
  - Reset mid-job abandons the job silently: no ack, no rsp_valid.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req != 0, select the first set bit searching k = ptr, ptr+1, … mod M.
  - Next edge: owner <= k; sort_data <= slice k; ack[k] <= 1; state -> LAUNCH.
  - If req == 0, stay in IDLE.
- LAUNCH (one cycle):
  - ack[owner] = 1 and sort_start = 1 this cycle only; timer <= 0; -> WAIT.
- WAIT:
  - sort_start = 0; timer increments each cycle.
  - sort_done = 1: rsp_data <= sort_result; rsp_err <= 0; -> RESP.
  - Else if timer == TIMEOUT-1: rsp_data <= 0; rsp_err <= 1; timeout_flag <= 1; -> RESP.
  - If sort_done and the timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid[owner] = 1; rsp_data and rsp_err held stable until rsp_valid[owner] & rsp_ready[owner].
  - On handshake: ptr <= (owner+1) mod M; job_count increments (saturating); rsp_valid cleared -> IDLE.
  - rsp_ready from non-owners is ignored.
- sort_done outside WAIT is ignored.
- sort_start is low in RESP and IDLE, so there are ≥2 low cycles between launches; the sorter's rising-edge detect re-arms.
- ack latency: req seen in IDLE at edge t; ack high in cycle t+1.
  - Requester may drop req from cycle t+2.
  - Requester must not change its slice until ack.
- A req deasserted before being sampled in IDLE is never granted.
- Throughput: one job per (sorter latency + 3 + response-wait) cycles.
- Fairness: under continuous requests from all M, grants rotate strictly 0,1,…,M-1; no requester waits more than M-1 jobs.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
1. Single job, paired with fsm_sort: M=3, req[1]=1, slice1={9,3,7,1,8,2} (element 0 first) -> ack[1] for 1 cycle; sort_start 1-cycle pulse; rsp_valid[1] with rsp_data={1,2,3,7,8,9}, rsp_err=0; job_count=1.
2. Round-robin: req=3'b111 held, each requester re-requests after its response -> grant order 0,1,2,0,1,2; each ack exactly one cycle; owner tracks.
3. Backpressure: hold rsp_ready[2]=0 for 10 cycles -> rsp_valid[2] and rsp_data stable, busy=1, no new ack; release -> IDLE next cycle.
4. Timeout: sorter model never asserts sort_done, TIMEOUT=32 -> 32 cycles after LAUNCH, rsp_valid[owner]=1 with rsp_err=1, rsp_data=0, timeout_flag=1 (sticky across a later good job).
5. Reset mid-WAIT: rst=0 for one cycle -> next cycle all outputs 0, state IDLE, pointer 0; a subsequent late sort_done pulse produces no rsp_valid.
6. Duplicates and extremes: slice0={255,0,255,0,128,128} -> rsp_data equals the vector returned on sort_result, unmodified.
   - Start gap check: sort_start low for ≥2 cycles between consecutive launches.
